// File: rtl/rib_rr_master_arb_if.sv
// rib_rr_master_arb_if
// Bus bundle for the round-robin RIB master arbiter. It carries MASTERS
// upstream master ports, packed so that master k sits at slice k, and the
// single downstream slave port.
// Signal names keep the arbiter-relative i_/o_ prefixes, so the bundle reads
// the same as the arbiter's own port list.
//   slave  modport : the arbiter's view (it serves the upstream masters)
//   master modport : the environment's view (masters plus downstream slave)
interface rib_rr_master_arb_if #(
    parameter int MASTERS = 3
);
    // upstream master side
    logic [32*MASTERS-1:0] i_ribm_addr;
    logic [MASTERS-1:0]    i_ribm_wrcs;
    logic [4*MASTERS-1:0]  i_ribm_mask;
    logic [32*MASTERS-1:0] i_ribm_wdata;
    logic [32*MASTERS-1:0] o_ribm_rdata;
    logic [MASTERS-1:0]    i_ribm_req;
    logic [MASTERS-1:0]    o_ribm_gnt;
    logic [MASTERS-1:0]    o_ribm_rsp;
    logic [MASTERS-1:0]    i_ribm_rdy;
    // downstream slave side
    logic [31:0]           o_ribs_addr;
    logic                  o_ribs_wrcs;
    logic [3:0]            o_ribs_mask;
    logic [31:0]           o_ribs_wdata;
    logic [31:0]           i_ribs_rdata;
    logic                  o_ribs_req;
    logic                  i_ribs_gnt;
    logic                  i_ribs_rsp;
    logic                  o_ribs_rdy;

    modport slave (
        input  i_ribm_addr, i_ribm_wrcs, i_ribm_mask, i_ribm_wdata,
        input  i_ribm_req, i_ribm_rdy,
        output o_ribm_rdata, o_ribm_gnt, o_ribm_rsp,
        output o_ribs_addr, o_ribs_wrcs, o_ribs_mask, o_ribs_wdata,
        output o_ribs_req, o_ribs_rdy,
        input  i_ribs_rdata, i_ribs_gnt, i_ribs_rsp
    );

    modport master (
        output i_ribm_addr, i_ribm_wrcs, i_ribm_mask, i_ribm_wdata,
        output i_ribm_req, i_ribm_rdy,
        input  o_ribm_rdata, o_ribm_gnt, o_ribm_rsp,
        input  o_ribs_addr, o_ribs_wrcs, o_ribs_mask, o_ribs_wdata,
        input  o_ribs_req, o_ribs_rdy,
        output i_ribs_rdata, i_ribs_gnt, i_ribs_rsp
    );
endinterface

// File: rtl/rib_rr_master_arb.sv
// rib_rr_master_arb
// Round-robin arbiter that places MASTERS RIB masters onto one RIB slave port.
// - The winner holds the slave port until its address handshake completes.
// - Up to DEPTH granted-but-unanswered transfers are remembered in an ID FIFO,
//   so in-order slave responses are routed back to the master that issued them.
// Ports:
//   i_clk, i_rst   : clock and synchronous active-high reset
//   bus            : rib_rr_master_arb_if.slave (master ports and slave port)
//   o_outstanding  : number of transfers granted and not yet responded
//   o_rsp_err      : sticky flag, set when a slave response arrives with
//                    nothing outstanding; cleared only by reset
module rib_rr_master_arb #(
    parameter  int MASTERS = 3,
    parameter  int DEPTH   = 2,
    localparam int ID_W    = (MASTERS > 1) ? $clog2(MASTERS) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    rib_rr_master_arb_if.slave  bus,
    output logic [CNT_W-1:0]    o_outstanding,
    output logic                o_rsp_err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ID_W-1:0]  ptr_r;
    logic             lock_r;
    logic [ID_W-1:0]  lock_id_r;
    logic [ID_W-1:0]  fifo_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             rsp_err_r;

    logic [ID_W-1:0]  hi_win_s;
    logic             hi_found_s;
    logic [ID_W-1:0]  lo_win_s;
    logic             lo_found_s;
    logic [ID_W-1:0]  winner_s;
    logic [ID_W-1:0]  head_s;
    logic             head_rdy_s;
    logic             full_s;
    logic             empty_s;
    logic             req_s;
    logic             hs_s;
    logic             rdy_s;
    logic             pop_s;
    logic             err_s;

    // FIFO pointer advance with wrap at DEPTH
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Master index advance with wrap at MASTERS (also for non-power-of-2)
    function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] id);
        return (id == ID_W'(MASTERS - 1)) ? '0 : id + ID_W'(1);
    endfunction

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == '0);
    assign head_s  = fifo_r[rd_ptr_r];
    // Full blocks the request even if a pop happens this cycle, so no path
    // exists from the slave response to the slave request.
    assign req_s   = (|bus.i_ribm_req) & ~full_s & ~i_rst;
    assign hs_s    = req_s & bus.i_ribs_gnt;
    // With nothing outstanding the slave response is drained and flagged.
    assign rdy_s   = ~i_rst & (empty_s ? bus.i_ribs_rsp : head_rdy_s);
    assign pop_s   = bus.i_ribs_rsp & rdy_s & ~empty_s;
    assign err_s   = bus.i_ribs_rsp & empty_s & ~i_rst;

    assign bus.o_ribs_req   = req_s;
    assign bus.o_ribs_rdy   = rdy_s;
    assign bus.o_ribm_rdata = {MASTERS{bus.i_ribs_rdata}};
    assign o_outstanding    = count_r;
    assign o_rsp_err        = rsp_err_r;

    // Round-robin search: the lowest requester at or above ptr wins, else the
    // lowest requester below ptr; a held lock overrides the search.
    always_comb begin
        hi_win_s   = '0;
        hi_found_s = 1'b0;
        lo_win_s   = '0;
        lo_found_s = 1'b0;
        for (int k = MASTERS - 1; k >= 0; k--) begin
            if (bus.i_ribm_req[k] && (ID_W'(k) >= ptr_r)) begin
                hi_found_s = 1'b1;
                hi_win_s   = ID_W'(k);
            end else if (bus.i_ribm_req[k]) begin
                lo_found_s = 1'b1;
                lo_win_s   = ID_W'(k);
            end else begin
                // master k not requesting: not a candidate
            end
        end
        if (lock_r) begin
            winner_s = lock_id_r;
        end else if (hi_found_s) begin
            winner_s = hi_win_s;
        end else if (lo_found_s) begin
            winner_s = lo_win_s;
        end else begin
            winner_s = ptr_r;
        end
    end

    // Payload mux and per-master grant for the current winner
    always_comb begin
        bus.o_ribs_addr  = '0;
        bus.o_ribs_wrcs  = 1'b0;
        bus.o_ribs_mask  = '0;
        bus.o_ribs_wdata = '0;
        bus.o_ribm_gnt   = '0;
        for (int k = 0; k < MASTERS; k++) begin
            if (ID_W'(k) == winner_s) begin
                bus.o_ribs_addr   = bus.i_ribm_addr[k*32 +: 32];
                bus.o_ribs_wrcs   = bus.i_ribm_wrcs[k];
                bus.o_ribs_mask   = bus.i_ribm_mask[k*4 +: 4];
                bus.o_ribs_wdata  = bus.i_ribm_wdata[k*32 +: 32];
                bus.o_ribm_gnt[k] = hs_s;
            end else begin
                bus.o_ribm_gnt[k] = 1'b0;
            end
        end
    end

    // Response routing to the master at the head of the ID FIFO
    always_comb begin
        head_rdy_s     = 1'b0;
        bus.o_ribm_rsp = '0;
        for (int k = 0; k < MASTERS; k++) begin
            if (ID_W'(k) == head_s) begin
                head_rdy_s        = bus.i_ribm_rdy[k];
                bus.o_ribm_rsp[k] = bus.i_ribs_rsp & ~empty_s & ~i_rst;
            end else begin
                bus.o_ribm_rsp[k] = 1'b0;
            end
        end
    end

    // Arbitration state: rotating pointer and the winner lock
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_r     <= '0;
            lock_r    <= 1'b0;
            lock_id_r <= '0;
        end else if (hs_s) begin
            ptr_r  <= id_inc(winner_s);
            lock_r <= 1'b0;
        end else if (req_s) begin
            lock_r    <= 1'b1;
            lock_id_r <= winner_s;
        end else begin
            lock_r <= lock_r;
        end
    end

    // ID FIFO storage and pointers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= '0;
            end
        end else begin
            if (hs_s) begin
                fifo_r[wr_ptr_r] <= winner_s;
                wr_ptr_r         <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Outstanding count and sticky response-error flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_r   <= '0;
            rsp_err_r <= 1'b0;
        end else begin
            case ({hs_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            rsp_err_r <= rsp_err_r | err_s;
        end
    end
endmodule

// File: tb/tb_rib_rr_master_arb.sv
// tb_rib_rr_master_arb
// Self-checking bench for rib_rr_master_arb (MASTERS=3, DEPTH=2).
// Directed scenarios use constant expectations; the random scenario uses a
// queue-based reference model of the arbitration and response-routing rules.
module tb_rib_rr_master_arb;
    localparam int M  = 3;
    localparam int D  = 2;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] outstanding;
    logic          rsp_err;
    int            n_checks = 0;
    int            n_fail   = 0;

    rib_rr_master_arb_if #(.MASTERS(M)) bus ();

    rib_rr_master_arb #(.MASTERS(M), .DEPTH(D)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus),
        .o_outstanding(outstanding),
        .o_rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    int     m_ptr;
    bit     m_lock;
    int     m_lock_id;
    int     m_q[$];
    bit     m_err;
    // Expected values for the current cycle
    int     e_win;
    bit     e_req;
    logic [M-1:0] e_gnt;
    logic [M-1:0] e_rsp;
    bit     e_rdy;
    logic [68:0]  e_pay;

    task automatic model_eval();
        bit found;
        int c;
        found = 1'b0;
        e_req = (bus.i_ribm_req != '0) && (m_q.size() < D) && !rst;
        e_win = m_ptr;
        if (m_lock) e_win = m_lock_id;
        else begin
            for (int off = 0; off < M; off++) begin
                c = (m_ptr + off) % M;
                if (!found && bus.i_ribm_req[c]) begin
                    e_win = c;
                    found = 1'b1;
                end
            end
        end
        e_gnt = (e_req && bus.i_ribs_gnt) ? (3'b001 << e_win) : 3'b000;
        e_rdy = !rst && ((m_q.size() == 0) ? bus.i_ribs_rsp : bus.i_ribm_rdy[m_q[0]]);
        e_rsp = (!rst && bus.i_ribs_rsp && m_q.size() != 0) ? (3'b001 << m_q[0]) : 3'b000;
        e_pay = {bus.i_ribm_addr[e_win*32 +: 32], bus.i_ribm_wdata[e_win*32 +: 32],
                 bus.i_ribm_mask[e_win*4 +: 4], bus.i_ribm_wrcs[e_win]};
    endtask

    task automatic model_commit();
        bit was_empty;
        if (rst) begin
            m_ptr = 0; m_lock = 1'b0; m_lock_id = 0; m_err = 1'b0;
            m_q.delete();
        end else begin
            was_empty = (m_q.size() == 0);
            if (bus.i_ribs_rsp && was_empty) m_err = 1'b1;
            if (bus.i_ribs_rsp && e_rdy && !was_empty) void'(m_q.pop_front());
            if (e_req && bus.i_ribs_gnt) begin
                m_q.push_back(e_win);
                m_ptr  = (e_win + 1) % M;
                m_lock = 1'b0;
            end else if (e_req) begin
                m_lock    = 1'b1;
                m_lock_id = e_win;
            end
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic clock();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive_payload(input int k, input logic [31:0] a);
        bus.i_ribm_addr[k*32 +: 32]  = a;
        bus.i_ribm_wdata[k*32 +: 32] = a ^ 32'h5A5A_5A5A;
        bus.i_ribm_mask[k*4 +: 4]    = a[7:4];
        bus.i_ribm_wrcs[k]           = a[8];
    endtask

    task automatic idle();
        bus.i_ribm_req   = 3'b000;
        bus.i_ribm_rdy   = 3'b111;
        bus.i_ribs_gnt   = 1'b0;
        bus.i_ribs_rsp   = 1'b0;
        bus.i_ribs_rdata = 32'h0000_0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        settle();
        clock();
        rst = 1'b0;
    endtask

    // Grants every pending request and answers every outstanding transfer.
    task automatic drain();
        bit done;
        logic [M-1:0] g;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            if (bus.i_ribm_req == '0 && m_q.size() == 0) done = 1'b1;
            else begin
                bus.i_ribs_gnt = 1'b1;
                bus.i_ribs_rsp = (m_q.size() != 0);
                bus.i_ribm_rdy = 3'b111;
                settle();
                g = e_gnt;
                clock();
                bus.i_ribm_req = bus.i_ribm_req & ~g;
            end
        end
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_ribm_req = 3'b111; bus.i_ribs_gnt = 1'b1; bus.i_ribs_rsp = 1'b1;
        settle();
        clock();
        settle();
        n_checks++;
        if ({bus.o_ribs_req, bus.o_ribm_gnt, bus.o_ribm_rsp, bus.o_ribs_rdy} !== 8'h00)
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {bus.o_ribs_req, bus.o_ribm_gnt, bus.o_ribm_rsp, bus.o_ribs_rdy});
        n_checks++;
        if ({outstanding, rsp_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: got cnt=%0d err=%b expected cnt=0 err=0", outstanding, rsp_err);
        end
        if ({bus.o_ribs_req, bus.o_ribm_gnt, bus.o_ribm_rsp, bus.o_ribs_rdy} !== 8'h00) n_fail++;
        rst = 1'b0;
        idle();
        settle();
        clock();
    endtask

    task automatic test_rr_order();
        logic [M-1:0] exp;
        for (int k = 0; k < M; k++) drive_payload(k, 32'h1000_0000 + k);
        bus.i_ribs_gnt = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.i_ribm_req   = (i < 6) ? 3'b111 : 3'b000;
            bus.i_ribs_rsp   = (i > 0);
            bus.i_ribs_rdata = 32'hA000_0000 + i;
            settle();
            if (i < 6) begin
                exp = 3'b001 << (i % 3);
                n_checks++;
                if (bus.o_ribm_gnt !== exp) begin
                    n_fail++;
                    $display("FAIL rr_gnt[%0d]: got %b expected %b", i, bus.o_ribm_gnt, exp);
                end
                n_checks++;
                if (bus.o_ribs_addr !== 32'h1000_0000 + (i % 3)) begin
                    n_fail++;
                    $display("FAIL rr_addr[%0d]: got %h expected %h", i, bus.o_ribs_addr, 32'h1000_0000 + (i % 3));
                end
            end
            if (i > 0) begin
                exp = 3'b001 << ((i - 1) % 3);
                n_checks++;
                if (bus.o_ribm_rsp !== exp) begin
                    n_fail++;
                    $display("FAIL rr_rsp[%0d]: got %b expected %b", i, bus.o_ribm_rsp, exp);
                end
            end
            clock();
            n_checks++;
            if (outstanding !== ((i < 6) ? 2'd1 : 2'd0)) begin
                n_fail++;
                $display("FAIL rr_outstanding[%0d]: got %0d expected %0d", i, outstanding, (i < 6) ? 1 : 0);
            end
        end
        idle();
    endtask

    task automatic test_lock();
        do_reset();
        for (int k = 0; k < M; k++) drive_payload(k, 32'h2000_0000 + k);
        bus.i_ribm_req = 3'b110;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.i_ribm_req = 3'b111;
            settle();
            n_checks++;
            if (bus.o_ribs_addr !== 32'h2000_0001 || bus.o_ribm_gnt !== 3'b000 || bus.o_ribs_req !== 1'b1) begin
                n_fail++;
                $display("FAIL lock_hold[%0d]: got addr=%h gnt=%b req=%b expected addr=20000001 gnt=000 req=1",
                         i, bus.o_ribs_addr, bus.o_ribm_gnt, bus.o_ribs_req);
            end
            clock();
        end
        bus.i_ribs_gnt = 1'b1;
        settle();
        n_checks++;
        if (bus.o_ribm_gnt !== 3'b010) begin
            n_fail++;
            $display("FAIL lock_gnt: got %b expected 010", bus.o_ribm_gnt);
        end
        clock();
        bus.i_ribm_req = 3'b101;
        settle();
        n_checks++;
        if (bus.o_ribm_gnt !== 3'b100) begin
            n_fail++;
            $display("FAIL lock_next_winner: got %b expected 100", bus.o_ribm_gnt);
        end
        clock();
        bus.i_ribm_req = 3'b001;
        drain();
        n_checks++;
        if (outstanding !== 2'd0) begin
            n_fail++;
            $display("FAIL lock_drain: got %0d expected 0", outstanding);
        end
    endtask

    task automatic test_full();
        do_reset();
        bus.i_ribs_gnt = 1'b1;
        bus.i_ribm_req = 3'b100;
        settle();
        n_checks++;
        if (bus.o_ribm_gnt !== 3'b100) begin
            n_fail++;
            $display("FAIL full_gnt2: got %b expected 100", bus.o_ribm_gnt);
        end
        clock();
        bus.i_ribm_req = 3'b001;
        settle();
        n_checks++;
        if (bus.o_ribm_gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL full_gnt0: got %b expected 001", bus.o_ribm_gnt);
        end
        clock();
        bus.i_ribm_req = 3'b010;
        settle();
        n_checks++;
        if (bus.o_ribs_req !== 1'b0 || bus.o_ribm_gnt !== 3'b000 || outstanding !== 2'd2) begin
            n_fail++;
            $display("FAIL full_block: got req=%b gnt=%b cnt=%0d expected req=0 gnt=000 cnt=2",
                     bus.o_ribs_req, bus.o_ribm_gnt, outstanding);
        end
        clock();
        bus.i_ribs_gnt   = 1'b0;
        bus.i_ribs_rsp   = 1'b1;
        bus.i_ribs_rdata = 32'hDEAD_BEEF;
        settle();
        n_checks++;
        if (bus.o_ribm_rsp !== 3'b100 || bus.o_ribm_rdata[2*32 +: 32] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL full_rsp_first: got rsp=%b rdata=%h expected rsp=100 rdata=deadbeef",
                     bus.o_ribm_rsp, bus.o_ribm_rdata[2*32 +: 32]);
        end
        clock();
        n_checks++;
        if (outstanding !== 2'd1) begin
            n_fail++;
            $display("FAIL full_pop1: got %0d expected 1", outstanding);
        end
        bus.i_ribs_rdata = 32'h0BAD_F00D;
        settle();
        n_checks++;
        if (bus.o_ribm_rsp !== 3'b001 || bus.o_ribm_rdata[31:0] !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL full_rsp_second: got rsp=%b rdata=%h expected rsp=001 rdata=0badf00d",
                     bus.o_ribm_rsp, bus.o_ribm_rdata[31:0]);
        end
        clock();
        drain();
        n_checks++;
        if (outstanding !== 2'd0) begin
            n_fail++;
            $display("FAIL full_drain: got %0d expected 0", outstanding);
        end
    endtask

    task automatic test_rdy_stall();
        do_reset();
        bus.i_ribm_req = 3'b010;
        bus.i_ribs_gnt = 1'b1;
        settle();
        clock();
        idle();
        bus.i_ribs_rsp = 1'b1;
        bus.i_ribm_rdy = 3'b101;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_checks++;
            if (bus.o_ribm_rsp !== 3'b010 || bus.o_ribs_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got rsp=%b rdy=%b expected rsp=010 rdy=0",
                         i, bus.o_ribm_rsp, bus.o_ribs_rdy);
            end
            clock();
            n_checks++;
            if (outstanding !== 2'd1) begin
                n_fail++;
                $display("FAIL stall_count[%0d]: got %0d expected 1", i, outstanding);
            end
        end
        bus.i_ribm_rdy = 3'b111;
        settle();
        n_checks++;
        if (bus.o_ribs_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got rdy=%b expected 1", bus.o_ribs_rdy);
        end
        clock();
        n_checks++;
        if (outstanding !== 2'd0) begin
            n_fail++;
            $display("FAIL stall_pop: got %0d expected 0", outstanding);
        end
        idle();
    endtask

    task automatic test_rsp_err();
        bus.i_ribs_rsp = 1'b1;
        settle();
        n_checks++;
        if (bus.o_ribs_rdy !== 1'b1 || bus.o_ribm_rsp !== 3'b000) begin
            n_fail++;
            $display("FAIL err_drain: got rdy=%b rsp=%b expected rdy=1 rsp=000", bus.o_ribs_rdy, bus.o_ribm_rsp);
        end
        clock();
        idle();
        for (int i = 0; i < 3; i++) begin
            settle();
            clock();
        end
        n_checks++;
        if (rsp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected 1", rsp_err);
        end
        do_reset();
        n_checks++;
        if (rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b expected 0", rsp_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.i_ribm_req = 3'b011;
        bus.i_ribs_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            clock();
            bus.i_ribm_req = bus.i_ribm_req & ~e_gnt;
        end
        n_checks++;
        if (outstanding !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_fill: got %0d expected 2", outstanding);
        end
        rst = 1'b1;
        bus.i_ribm_req = 3'b111;
        bus.i_ribs_rsp = 1'b1;
        settle();
        n_checks++;
        if ({bus.o_ribs_req, bus.o_ribm_gnt, bus.o_ribm_rsp, bus.o_ribs_rdy} !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_forced: got %b expected 00000000",
                     {bus.o_ribs_req, bus.o_ribm_gnt, bus.o_ribm_rsp, bus.o_ribs_rdy});
        end
        clock();
        n_checks++;
        if (outstanding !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_cleared: got %0d expected 0", outstanding);
        end
        rst = 1'b0;
        bus.i_ribm_req = 3'b000;
        settle();
        n_checks++;
        if (bus.o_ribs_rdy !== 1'b1 || bus.o_ribm_rsp !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_late_rsp: got rdy=%b rsp=%b expected rdy=1 rsp=000", bus.o_ribs_rdy, bus.o_ribm_rsp);
        end
        clock();
        n_checks++;
        if (rsp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_late_err: got %b expected 1", rsp_err);
        end
        bus.i_ribs_rsp = 1'b0;
        bus.i_ribm_req = 3'b111;
        settle();
        n_checks++;
        if (bus.o_ribm_gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL mid_ptr_zero: got %b expected 001", bus.o_ribm_gnt);
        end
        clock();
        bus.i_ribm_req = 3'b110;
        drain();
        do_reset();
    endtask

    task automatic test_random();
        logic [M-1:0] rq;
        logic [M-1:0] granted;
        bit srsp;
        bit acc;
        do_reset();
        rq = 3'b000;
        srsp = 1'b0;
        for (int n = 0; n < 500; n++) begin
            for (int k = 0; k < M; k++) begin
                if (!rq[k] && $urandom_range(0, 2) == 0) begin
                    rq[k] = 1'b1;
                    drive_payload(k, $urandom);
                end
            end
            bus.i_ribm_req = rq;
            bus.i_ribs_gnt = ($urandom_range(0, 2) != 0);
            if (!srsp && m_q.size() != 0 && $urandom_range(0, 1) == 1) begin
                srsp = 1'b1;
                bus.i_ribs_rdata = $urandom;
            end
            bus.i_ribs_rsp = srsp;
            bus.i_ribm_rdy = 3'($urandom_range(0, 7));
            settle();
            n_checks++;
            if (bus.o_ribm_gnt !== e_gnt || bus.o_ribs_req !== e_req) begin
                n_fail++;
                $display("FAIL rand_gnt[%0d]: got gnt=%b req=%b expected gnt=%b req=%b",
                         n, bus.o_ribm_gnt, bus.o_ribs_req, e_gnt, e_req);
            end
            n_checks++;
            if (bus.o_ribm_rsp !== e_rsp || bus.o_ribs_rdy !== e_rdy) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: got rsp=%b rdy=%b expected rsp=%b rdy=%b",
                         n, bus.o_ribm_rsp, bus.o_ribs_rdy, e_rsp, e_rdy);
            end
            n_checks++;
            if ({bus.o_ribs_addr, bus.o_ribs_wdata, bus.o_ribs_mask, bus.o_ribs_wrcs} !== e_pay) begin
                n_fail++;
                $display("FAIL rand_payload[%0d]: got %h expected %h", n,
                         {bus.o_ribs_addr, bus.o_ribs_wdata, bus.o_ribs_mask, bus.o_ribs_wrcs}, e_pay);
            end
            acc = srsp && e_rdy;
            granted = e_gnt;
            clock();
            if (acc) srsp = 1'b0;
            rq = rq & ~granted;
            n_checks++;
            if (outstanding !== CW'(m_q.size()) || rsp_err !== m_err) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got cnt=%0d err=%b expected cnt=%0d err=%b",
                         n, outstanding, rsp_err, m_q.size(), m_err);
            end
        end
        bus.i_ribm_req = rq;
        drain();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int k = 0; k < M; k++) drive_payload(k, 32'h0000_0000);
        test_reset();
        test_rr_order();
        test_lock();
        test_full();
        test_rdy_stall();
        test_rsp_err();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rib_rr_master_arb.md
Name: rib_rr_master_arb

Overview:
- Parametrised successor to the fixed-priority RIB master selector.
- Arbitrates MASTERS RIB masters onto one RIB slave port using round-robin instead of fixed priority.
- Holds the winner stable until its address-phase handshake completes.
- Tracks up to DEPTH outstanding transfers in an ID FIFO, so pipelined responses route back to the correct master in order.
- Sits between core/DMA masters and the slave-select layer of the RIB fabric.

Parameters:
- MASTERS, 3: number of master ports; legal range 2..16.
- DEPTH, 2: maximum outstanding (granted, not yet responded) transfers; legal range 1..8.
- ID_W, $clog2(MASTERS): width of the stored master index (derived; do not override).
- CNT_W, $clog2(DEPTH+1): width of the outstanding counter (derived).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_ribm_addr  in  32*MASTERS  per-master address.
- i_ribm_wrcs  in  MASTERS  per-master read/write select.
- i_ribm_mask  in  4*MASTERS  per-master byte write mask.
- i_ribm_wdata  in  32*MASTERS  per-master write data.
- o_ribm_rdata  out  32*MASTERS  read data; i_ribs_rdata fanned to every master.
- i_ribm_req  in  MASTERS  per-master request.
- o_ribm_gnt  out  MASTERS  per-master grant (one-hot or zero).
- o_ribm_rsp  out  MASTERS  per-master response valid (one-hot or zero).
- i_ribm_rdy  in  MASTERS  per-master response accept.
- o_ribs_addr  out  32  to slave.
- o_ribs_wrcs  out  1  to slave.
- o_ribs_mask  out  4  to slave.
- o_ribs_wdata  out  32  to slave.
- i_ribs_rdata  in  32  from slave.
- o_ribs_req  out  1  request to slave.
- i_ribs_gnt  in  1  slave grant.
- i_ribs_rsp  in  1  slave response valid.
- o_ribs_rdy  out  1  response accept to slave.
- o_outstanding  out  CNT_W  current outstanding transfer count.
- o_rsp_err  out  1  sticky flag: slave response arrived with no transfer outstanding.

Behaviour:
Handshake rules
- Address phase completes on a cycle with req & gnt. A master holds req and payload stable until gnt.
- Response phase completes on a cycle with rsp & rdy. The slave holds rsp and rdata until rdy.

Arbitration
- Registered pointer ptr (ID_W bits), reset 0.
- Winner = first requesting master found searching ptr, ptr+1, … mod MASTERS.
- Registered lock (winner id plus lock bit): set when o_ribs_req=1 and i_ribs_gnt=0. While set, the winner is the locked id regardless of other requests. Cleared on the handshake cycle.
- On handshake with winner k: ptr <= (k+1) mod MASTERS. This wraps MASTERS-1 to 0, including non-power-of-2 MASTERS.
- o_ribs_req = |i_ribm_req & ~full & ~i_rst, where full = (o_outstanding == DEPTH).
- o_ribs_addr, wrcs, mask and wdata mux the winner's payload. With no request, they mux master ptr.
- o_ribm_gnt[k] = (k == winner) & o_ribs_req & i_ribs_gnt.

ID FIFO
- DEPTH entries of ID_W bits, with read pointer, write pointer and count. All three reset to 0.
- Push the winner id on the address handshake. Pop on i_ribs_rsp & o_ribs_rdy.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: req is blocked even if a pop occurs in the same cycle. This keeps the path from rsp to req free of combinational logic.
- Pointers wrap at DEPTH.

Response routing
- Head = FIFO[rd_ptr].
- o_ribm_rsp[k] = i_ribs_rsp & ~empty & (head == k).
- o_ribs_rdy = ~empty & i_ribm_rdy[head].

Response error
- If i_ribs_rsp=1 while empty: o_ribs_rdy=1 (drain the slave), no o_ribm_rsp asserts, and o_rsp_err <= 1.
- o_rsp_err clears only on reset.

Latency
- Zero-cycle combinational grant when the slave grants in the same cycle.
- The response may arrive as early as the cycle after the handshake.
- Back-to-back transfers sustain 1 per cycle while not full.

Reset (i_rst=1, sampled on posedge)
- ptr, lock, FIFO pointers, count and o_rsp_err go to 0.
- While i_rst is high, o_ribs_req, o_ribm_gnt, o_ribm_rsp and o_ribs_rdy are forced 0.
- Reset mid-transfer discards all outstanding IDs. Any late slave response after reset sets o_rsp_err.

Test Plan:
- MASTERS=3, DEPTH=2, all three req held high, slave gnt=1 every cycle, rsp one cycle later with rdy=1 -> grant order 0,1,2,0,1,2; ptr wraps 2->0; o_outstanding stays at 1.
- Masters 1 and 2 requesting, slave gnt held 0 for 3 cycles, then master 0 raises req -> o_ribs_addr stays on master 1 throughout; after gnt, master 2 wins next (not 0).
- Slave grants 2 transfers (masters 2 then 0), rsp withheld -> o_outstanding=2, o_ribs_req=0 despite master 1 req; rsp with rdata 0xDEADBEEF routes to master 2 first, then master 0.
- Head master rdy=0 while rsp=1 for 4 cycles -> rsp held at that master, count unchanged; on rdy=1, pop and count decrements by 1.
- Slave rsp=1 with count=0 -> o_ribs_rdy=1, all o_ribm_rsp=0, o_rsp_err=1 and stays 1 until i_rst.
- Assert i_rst with 2 outstanding -> next cycle o_outstanding=0, ptr=0, all outputs 0 while i_rst is high.
